// File: rtl/mic_pkg.sv
// Shared definitions for the PDM microphone frame path: defaults, sync byte,
// frame-packer state encoding and the header helper.
package mic_pkg;

    localparam int DEF_CH_COUNT = 20;
    localparam int DEF_DATA_W   = 16;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Low 16 bits of a header word: sync byte followed by the frame sequence number.
    function automatic logic [15:0] hdr16(input logic [7:0] seq);
        return {SYNC_BYTE, seq};
    endfunction

endpackage

// File: rtl/pdm_sample_bank.sv
// CH_COUNT x DATA_W register bank: whole-set parallel load, indexed word read
// and a flat view of the full set for bank-to-bank copies.
module pdm_sample_bank
    import mic_pkg::*;
#(
    parameter int CH_COUNT = DEF_CH_COUNT,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IDX_W    = $clog2(CH_COUNT + 1)
) (
    input  logic                         clk,
    input  logic                         load_i,
    input  logic [CH_COUNT*DATA_W-1:0]   load_data_i,
    input  logic [IDX_W-1:0]             rd_idx_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic [CH_COUNT*DATA_W-1:0]   bank_o
);

    logic [CH_COUNT*DATA_W-1:0] bank_q;

    // Sample storage carries no reset; it is always loaded before it is read.
    always_ff @(posedge clk) begin
        if (load_i) begin
            bank_q <= load_data_i;
        end
    end

    // Out-of-range indices read as zero.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_data_o = bank_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bank_o = bank_q;

endmodule

// File: rtl/pdm_frame_packer.sv
// Serialises each captured multichannel sample set into a framed valid/ready
// stream (header + one word per channel), with a one-deep pending buffer.
module pdm_frame_packer
    import mic_pkg::*;
#(
    parameter int CH_COUNT = DEF_CH_COUNT,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_stb,
    input  logic [CH_COUNT*DATA_W-1:0]  ch_data,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_first,
    output logic                        m_last,
    output logic                        overflow,
    input  logic                        clr_overflow,
    output logic [7:0]                  drop_cnt
);

    localparam int IDX_W = $clog2(CH_COUNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_COUNT - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [7:0]          seq_q;
    logic                m_valid_q;
    logic                m_first_q;
    logic                m_last_q;
    logic [DATA_W-1:0]   m_data_q;

    logic                pend_valid_q, pend_valid_d;
    logic                overflow_q,   overflow_d;
    logic [7:0]          drop_cnt_q,   drop_cnt_d;

    logic                xfer;
    logic                last_xfer;
    logic                consume;
    logic                capture;
    logic                drop;
    logic [IDX_W-1:0]    act_rd_idx;
    logic [DATA_W-1:0]   act_word;
    logic [CH_COUNT*DATA_W-1:0] pend_bank;
    logic [DATA_W-1:0]   pend_rd_unused;
    logic [CH_COUNT*DATA_W-1:0] act_bank_unused;

    function automatic logic [DATA_W-1:0] header_word(input logic [7:0] s);
        logic [DATA_W-1:0] w;
        w       = '0;
        w[15:0] = hdr16(s);
        return w;
    endfunction

    assign xfer      = m_valid_q && m_ready;
    assign last_xfer = xfer && (state_q == ST_DATA) && (idx_q == LAST_IDX);

    // The pending set moves to the active bank when a frame starts from idle
    // or when the previous frame's last word leaves.
    assign consume = pend_valid_q && ((state_q == ST_IDLE) || last_xfer);
    assign capture = sample_stb && (!pend_valid_q || consume);
    assign drop    = sample_stb && pend_valid_q && !consume;

    // Prefetch the word that follows the current one so m_data stays registered.
    assign act_rd_idx = (state_q == ST_HDR) ? '0 : idx_q + IDX_W'(1);

    pdm_sample_bank #(
        .CH_COUNT (CH_COUNT),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_pend_bank (
        .clk         (clk),
        .load_i      (capture),
        .load_data_i (ch_data),
        .rd_idx_i    ('0),
        .rd_data_o   (pend_rd_unused),
        .bank_o      (pend_bank)
    );

    pdm_sample_bank #(
        .CH_COUNT (CH_COUNT),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_act_bank (
        .clk         (clk),
        .load_i      (consume),
        .load_data_i (pend_bank),
        .rd_idx_i    (act_rd_idx),
        .rd_data_o   (act_word),
        .bank_o      (act_bank_unused)
    );

    always_comb begin
        pend_valid_d = pend_valid_q;
        if (capture) begin
            pend_valid_d = 1'b1;
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end

        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            pend_valid_q <= pend_valid_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            seq_q     <= 8'd0;
            m_valid_q <= 1'b0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_valid_q) begin
                        state_q   <= ST_HDR;
                        m_valid_q <= 1'b1;
                        m_first_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        m_data_q  <= header_word(seq_q);
                    end
                end

                ST_HDR: begin
                    if (xfer) begin
                        state_q   <= ST_DATA;
                        idx_q     <= '0;
                        m_first_q <= 1'b0;
                        m_last_q  <= (LAST_IDX == '0);
                        m_data_q  <= act_word;
                    end
                end

                ST_DATA: begin
                    if (xfer) begin
                        if (idx_q == LAST_IDX) begin
                            seq_q <= seq_q + 8'd1;
                            // Chain straight into the next header when a set is waiting.
                            if (pend_valid_q) begin
                                state_q   <= ST_HDR;
                                m_first_q <= 1'b1;
                                m_last_q  <= 1'b0;
                                m_data_q  <= header_word(seq_q + 8'd1);
                            end else begin
                                state_q   <= ST_IDLE;
                                m_valid_q <= 1'b0;
                                m_first_q <= 1'b0;
                                m_last_q  <= 1'b0;
                            end
                        end else begin
                            idx_q    <= idx_q + IDX_W'(1);
                            m_last_q <= ((idx_q + IDX_W'(1)) == LAST_IDX);
                            m_data_q <= act_word;
                        end
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    m_valid_q <= 1'b0;
                    m_first_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_first  = m_first_q;
    assign m_last   = m_last_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pdm_frame_packer.sv
// Scoreboard bench for pdm_frame_packer: a frame-level reference model queues
// expected words; an independent monitor checks every accepted word.
module tb_pdm_frame_packer;
    import mic_pkg::*;

    localparam int CH = 20;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_stb = 1'b0;
    logic [CH*DW-1:0]  ch_data = '0;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_first;
    logic              m_last;
    logic              overflow;
    logic              clr_overflow = 1'b0;
    logic [7:0]        drop_cnt;

    always #5 clk = ~clk;

    pdm_frame_packer #(.CH_COUNT(CH), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_stb   (sample_stb),
        .ch_data      (ch_data),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_first      (m_first),
        .m_last       (m_last),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .drop_cnt     (drop_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
    } word_t;

    word_t sb_q[$];
    int    checks = 0;
    int    passed = 0;

    // Reference model: a pending slot, a transmitter busy with N words left,
    // and counters. Expected values for the current cycle are snapshotted.
    bit               md_busy;
    int               md_rem;
    bit               md_pend;
    logic [CH*DW-1:0] md_pend_data;
    logic [7:0]       md_seq;
    bit               md_ovf;
    int               md_cnt;
    bit               e_valid;
    bit               e_ovf;
    int               e_cnt;
    bit               e_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        sb_q.delete();
        md_busy = 0; md_rem = 0; md_pend = 0; md_pend_data = '0;
        md_seq = 8'd0; md_ovf = 0; md_cnt = 0;
        e_valid = 0; e_ovf = 0; e_cnt = 0;
    endtask

    task automatic push_frame(input logic [CH*DW-1:0] d, input logic [7:0] s);
        word_t w;
        w.data = {8'hA5, s}; w.first = 1'b1; w.last = 1'b0;
        sb_q.push_back(w);
        for (int i = 0; i < CH; i++) begin
            w.data  = d[i*DW +: DW];
            w.first = 1'b0;
            w.last  = (i == CH - 1);
            sb_q.push_back(w);
        end
    endtask

    task automatic step(input bit stb, input logic [CH*DW-1:0] d, input bit rdy, input bit clr);
        bit xfer, lastx, cons, cap, drp;
        @(posedge clk); #1;
        rst = 1'b0;
        e_valid = md_busy; e_ovf = md_ovf; e_cnt = md_cnt; e_chk = 1'b1;
        sample_stb = stb; ch_data = d; m_ready = rdy; clr_overflow = clr;
        xfer  = md_busy && rdy;
        lastx = xfer && (md_rem == 1);
        cons  = md_pend && (!md_busy || lastx);
        cap   = stb && (!md_pend || cons);
        drp   = stb && md_pend && !cons;
        if (xfer) md_rem--;
        if (lastx) md_busy = 0;
        if (cons) begin
            push_frame(md_pend_data, md_seq);
            md_seq  = md_seq + 8'd1;
            md_busy = 1;
            md_rem  = CH + 1;
            md_pend = 0;
        end
        if (cap) begin
            md_pend = 1;
            md_pend_data = d;
        end
        if (drp) begin
            md_ovf = 1;
            if (md_cnt < 255) md_cnt++;
        end else if (clr) begin
            md_ovf = 0;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, '0, rdy, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b1; sample_stb = 1'b0; clr_overflow = 1'b0; m_ready = 1'b1;
            model_reset();
        end
    endtask

    function automatic logic [CH*DW-1:0] rand_set();
        logic [CH*DW-1:0] d;
        for (int i = 0; i < CH; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    function automatic logic [CH*DW-1:0] ramp_set();
        logic [CH*DW-1:0] d;
        for (int i = 0; i < CH; i++) d[i*DW +: DW] = DW'(i * 100);
        return d;
    endfunction

    // Monitor: checks outputs against the snapshot and pops on every transfer.
    bit   prev_stall = 1'b0;
    logic [DW+2:0] prev_word;
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_m_valid", 32'(m_valid), 32'd0);
                check("rst_m_data", 32'(m_data), 32'd0);
                check("rst_m_first", 32'(m_first), 32'd0);
                check("rst_m_last", 32'(m_last), 32'd0);
                check("rst_overflow", 32'(overflow), 32'd0);
                check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
                prev_stall = 1'b0;
            end else if (e_chk) begin
                check("m_valid", 32'(m_valid), 32'(e_valid));
                check("overflow", 32'(overflow), 32'(e_ovf));
                check("drop_cnt", 32'(drop_cnt), 32'(e_cnt));
                if (prev_stall) check("stall_hold", 32'({m_valid, m_first, m_last, m_data}), 32'(prev_word));
                if (m_valid && m_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_word: got %0h expected none at %0t", m_data, $time);
                    end else begin
                        w = sb_q.pop_front();
                        check("word_data", 32'(m_data), 32'(w.data));
                        check("word_first", 32'(m_first), 32'(w.first));
                        check("word_last", 32'(m_last), 32'(w.last));
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_word  = {m_valid, m_first, m_last, m_data};
            end
        end
    end

    initial begin
        int rdy_thr;
        bit stb, rdy, clr;
        model_reset();
        do_reset(3);

        // Single frame with ramp payload; header two cycles after the strobe.
        step(1, ramp_set(), 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        check("hdr_latency_data", 32'(m_data), 32'h0000A500);
        check("hdr_latency_first", 32'(m_first), 32'd1);
        idle(25, 1);

        // Backpressure pattern 1,0,0,1 across the frame.
        step(1, rand_set(), 1, 0);
        for (int i = 0; i < 60; i++) step(0, '0, (i % 4 == 0) || (i % 4 == 3), 0);
        idle(5, 1);

        // Two strobes five cycles apart: back-to-back frames.
        step(1, rand_set(), 1, 0);
        idle(4, 1);
        step(1, rand_set(), 1, 0);
        idle(50, 1);

        // Three strobes while stalled: the third is dropped.
        do_reset(2);
        step(1, rand_set(), 0, 0);
        idle(4, 0);
        step(1, rand_set(), 0, 0);
        idle(4, 0);
        step(1, rand_set(), 0, 0);
        step(0, '0, 0, 0);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_count", 32'(drop_cnt), 32'd1);
        idle(60, 1);

        // Clear coinciding with a drop keeps overflow; a lone clear removes it.
        do_reset(2);
        step(1, rand_set(), 0, 0);
        idle(3, 0);
        step(1, rand_set(), 0, 0);
        step(1, rand_set(), 0, 1);
        step(0, '0, 0, 0);
        check("clr_vs_drop", 32'(overflow), 32'd1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        check("clr_alone", 32'(overflow), 32'd0);
        check("clr_keeps_cnt", 32'(drop_cnt), 32'd1);
        idle(60, 1);

        // Reset in the middle of a frame; the next frame restarts at seq 0.
        step(1, rand_set(), 1, 0);
        idle(9, 1);
        do_reset(2);
        step(1, rand_set(), 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        check("post_rst_hdr", 32'(m_data), 32'h0000A500);
        idle(25, 1);

        // Randomised traffic with varying sink throughput.
        rdy_thr = 7;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_thr = $urandom_range(1, 10);
            stb = ($urandom_range(0, 13) == 0);
            rdy = ($urandom_range(0, 9) < rdy_thr);
            clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 999) == 0) do_reset(2);
            else step(stb, rand_set(), rdy, clr);
        end

        idle(4 * (CH + 1), 1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
